ep_bulk_in_mps: RTL

Parametrised bulk IN end-point with runtime-selectable max packet size (HS/FS), true zero-length-packet (ZDP) termination, and a multi-chunk circular buffer that can replay the in-flight chunk. It sits between a bulk AXI4-Stream data source and the USB packet-encoder MUX. Handshake, timeout and selection strobes come from the USB controller. Configuration events come from control pipe 0.

---
 rtl/ep_bulk_in_mps.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/ep_bulk_in_mps.sv
// Bulk IN end-point: byte FIFO carved into MPS-sized chunks, replayable on timeout,
// with optional zero-length-packet termination after an exact-MPS final chunk.
module ep_bulk_in_mps #(
  parameter int MAX_PACKET_LENGTH = 512,
  parameter int FS_PACKET_LENGTH  = 64,
  parameter int FIFO_DEPTH        = 2048,
  parameter int USE_ZDP           = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          set_conf_i,
  input  logic                          clr_conf_i,
  input  logic                          hs_mode_i,
  input  logic                          selected_i,
  input  logic                          ack_recv_i,
  input  logic                          timedout_i,
  output logic                          ep_ready_o,
  output logic                          stalled_o,
  output logic                          parity_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  input  logic                          s_tvalid,
  output logic                          s_tready,
  input  logic                          s_tlast,
  input  logic [7:0]                    s_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic                          m_tkeep,
  output logic                          m_tlast,
  output logic [7:0]                    m_tdata
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int MW = $clog2(MAX_PACKET_LENGTH) + 1;
  localparam logic [PW-1:0] DEPTH_W = PW'(FIFO_DEPTH);
  localparam logic [MW-1:0] HS_MPS  = MW'(MAX_PACKET_LENGTH);
  localparam logic [MW-1:0] FS_MPS  = MW'(FS_PACKET_LENGTH);

  typedef enum logic [2:0] {ST_IDLE, ST_SEND, ST_WAIT, ST_ZDP, ST_ZWAIT} state_t;
  state_t r_state, w_next;

  logic          r_cfg;
  logic [MW-1:0] r_mps, r_rcount;
  logic [PW-1:0] r_wr_ptr, r_rd_ptr, r_st_ptr, r_chunks;
  logic          r_zdp_pend, r_zdp_cap, r_parity;
  logic          r_out_valid, r_out_eoc, r_out_zdp;
  logic [7:0]    r_out_data;
  logic [9:0]    r_mem [FIFO_DEPTH];

  logic          w_clear, w_wr, w_eoc, w_zdp, w_hs, w_load, w_ack, w_tout, w_zack;
  logic [PW-1:0] w_level;
  logic [MW-1:0] w_mps_m1;

  assign w_clear  = reset | set_conf_i | clr_conf_i;
  assign w_level  = r_wr_ptr - r_st_ptr;
  assign w_mps_m1 = r_mps - MW'(1);
  assign s_tready = r_cfg && (w_level < DEPTH_W);
  assign w_wr     = s_tvalid && s_tready;
  assign w_eoc    = s_tlast || (r_rcount == w_mps_m1);
  assign w_zdp    = (USE_ZDP != 0) && s_tlast && (r_rcount == w_mps_m1);
  assign w_hs     = (r_state == ST_SEND) && r_out_valid && m_tready;
  // Stop fetching once the chunk's eoc byte sits in the output register, so
  // rd_ptr ends exactly at the chunk boundary when the packet is ACKed.
  assign w_load   = (r_state == ST_SEND) && (r_rd_ptr != r_wr_ptr) &&
                    (!r_out_valid || (m_tready && !r_out_eoc));
  assign w_ack    = (r_state == ST_WAIT) && selected_i && ack_recv_i;
  assign w_tout   = (r_state == ST_WAIT) && selected_i && timedout_i && !ack_recv_i;
  assign w_zack   = (r_state == ST_ZWAIT) && selected_i && ack_recv_i;

  assign level_o    = w_level;
  assign stalled_o  = ~r_cfg;
  assign parity_o   = r_parity;
  assign ep_ready_o = r_cfg && ((r_chunks != '0) || r_zdp_pend);

  always_ff @(posedge clock) begin
    if (w_clear) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    m_tvalid = 1'b0;
    m_tkeep  = 1'b0;
    m_tlast  = 1'b0;
    m_tdata  = 8'h00;
    case (r_state)
      ST_IDLE: begin
        if (selected_i && r_zdp_pend)          w_next = ST_ZDP;
        else if (selected_i && (r_chunks != '0)) w_next = ST_SEND;
        else                                   w_next = ST_IDLE;
      end
      ST_SEND: begin
        m_tvalid = r_out_valid;
        m_tkeep  = r_out_valid;
        m_tlast  = r_out_valid && r_out_eoc;
        m_tdata  = r_out_valid ? r_out_data : 8'h00;
        if (w_hs && r_out_eoc) w_next = ST_WAIT;
        else                   w_next = ST_SEND;
      end
      ST_WAIT: begin
        if (selected_i && (ack_recv_i || timedout_i)) w_next = ST_IDLE;
        else                                          w_next = ST_WAIT;
      end
      ST_ZDP: begin
        m_tvalid = 1'b1;
        m_tlast  = 1'b1;
        if (m_tready) w_next = ST_ZWAIT;
        else          w_next = ST_ZDP;
      end
      ST_ZWAIT: begin
        if (selected_i && (ack_recv_i || timedout_i)) w_next = ST_IDLE;
        else                                          w_next = ST_ZWAIT;
      end
      default: w_next = ST_IDLE;
    endcase
    if (!r_cfg) w_next = ST_IDLE;
  end

  always_ff @(posedge clock) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= {w_zdp, w_eoc, s_tdata};
  end

  always_ff @(posedge clock) begin
    if (w_clear) begin
      r_cfg       <= set_conf_i && !clr_conf_i && !reset;
      r_mps       <= (set_conf_i && !hs_mode_i) ? FS_MPS : HS_MPS;
      r_rcount    <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_st_ptr    <= '0;
      r_chunks    <= '0;
      r_zdp_pend  <= 1'b0;
      r_zdp_cap   <= 1'b0;
      r_parity    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_eoc   <= 1'b0;
      r_out_zdp   <= 1'b0;
      r_out_data  <= 8'h00;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
        r_rcount <= w_eoc ? '0 : r_rcount + MW'(1);
      end
      // A commit and a release in the same cycle cancel out.
      case ({w_wr && w_eoc, w_ack})
        2'b10:   r_chunks <= r_chunks + PW'(1);
        2'b01:   r_chunks <= r_chunks - PW'(1);
        default: r_chunks <= r_chunks;
      endcase
      if (w_tout)      r_rd_ptr <= r_st_ptr;
      else if (w_load) r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_tout) begin
        r_out_valid <= 1'b0;
      end else if (w_load) begin
        r_out_valid <= 1'b1;
        {r_out_zdp, r_out_eoc, r_out_data} <= r_mem[r_rd_ptr[AW-1:0]];
      end else if (w_hs) begin
        r_out_valid <= 1'b0;
      end
      if (w_hs && r_out_eoc) r_zdp_cap <= r_out_zdp;
      if (w_ack) begin
        r_st_ptr   <= r_rd_ptr;
        r_parity   <= ~r_parity;
        r_zdp_pend <= r_zdp_cap;
      end else if (w_zack) begin
        r_parity   <= ~r_parity;
        r_zdp_pend <= 1'b0;
      end
    end
  end

endmodule
